// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - MIPS decode/operand-select stage feeding the ID/EX register and ALU
module id_ex_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic        ValidIn,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic [31:0] ExResult,
    input  logic        MemRegWrite,
    input  logic [4:0]  MemRd,
    input  logic [31:0] MemData,
    input  logic        WbRegWrite,
    input  logic [4:0]  WbRd,
    input  logic [31:0] WbData,
    input  logic        StallIn,
    input  logic        Flush,
    output logic [31:0] BusA,
    output logic [31:0] BusB,
    output logic [1:0]  ALUControl,
    output logic [31:0] StoreData,
    output logic [4:0]  RdOut,
    output logic        RegWriteOut,
    output logic        MemReadOut,
    output logic        MemWriteOut,
    output logic        BranchOut,
    output logic        ValidOut,
    output logic        StallOut,
    output logic        IllegalOut
);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;

    assign opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign imm    = Instruction[15:0];
    assign funct  = Instruction[5:0];

    logic        dec_legal;
    logic [1:0]  dec_alu;
    logic        dec_use_imm;
    logic        dec_sext;
    logic        dec_reads_rt;
    logic        dec_rw;
    logic        dec_mr;
    logic        dec_mw;
    logic        dec_br;
    logic [4:0]  dec_rd;

    always_comb begin
        dec_legal    = 1'b0;
        dec_alu      = ALU_ADD;
        dec_use_imm  = 1'b0;
        dec_sext     = 1'b1;
        dec_reads_rt = 1'b0;
        dec_rw       = 1'b0;
        dec_mr       = 1'b0;
        dec_mw       = 1'b0;
        dec_br       = 1'b0;
        dec_rd       = rt;
        case (opcode)
            6'h00: begin
                dec_rd       = Instruction[15:11];
                dec_legal    = 1'b1;
                dec_reads_rt = 1'b1;
                dec_rw       = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec_alu = ALU_ADD;
                    6'h22, 6'h23: dec_alu = ALU_SUB;
                    6'h26:        dec_alu = ALU_XOR;
                    6'h2A:        dec_alu = ALU_SLT;
                    default: begin
                        dec_legal    = 1'b0;
                        dec_reads_rt = 1'b0;
                        dec_rw       = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09: begin
                dec_legal   = 1'b1;
                dec_use_imm = 1'b1;
                dec_rw      = 1'b1;
            end
            6'h0A: begin
                dec_legal   = 1'b1;
                dec_alu     = ALU_SLT;
                dec_use_imm = 1'b1;
                dec_rw      = 1'b1;
            end
            6'h0E: begin
                dec_legal   = 1'b1;
                dec_alu     = ALU_XOR;
                dec_use_imm = 1'b1;
                dec_sext    = 1'b0;
                dec_rw      = 1'b1;
            end
            6'h23: begin
                dec_legal   = 1'b1;
                dec_use_imm = 1'b1;
                dec_rw      = 1'b1;
                dec_mr      = 1'b1;
            end
            6'h2B: begin
                dec_legal    = 1'b1;
                dec_use_imm  = 1'b1;
                dec_reads_rt = 1'b1;
                dec_mw       = 1'b1;
            end
            6'h04: begin
                dec_legal    = 1'b1;
                dec_alu      = ALU_SUB;
                dec_reads_rt = 1'b1;
                dec_br       = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic [31:0] bus_a_q, bus_a_d;
    logic [31:0] bus_b_q, bus_b_d;
    logic [1:0]  alu_ctl_q, alu_ctl_d;
    logic [31:0] store_data_q, store_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        branch_q, branch_d;
    logic        valid_q, valid_d;
    logic        illegal_q, illegal_d;

    // Forwarding priority EX > MEM > WB > register file; r0 is hardwired to zero.
    logic        ex_hit_rs, mem_hit_rs, wb_hit_rs;
    logic        ex_hit_rt, mem_hit_rt, wb_hit_rt;
    logic [31:0] fwd_rs, fwd_rt;

    assign ex_hit_rs  = valid_q & reg_write_q & (rd_q == rs);
    assign mem_hit_rs = MemRegWrite & (MemRd == rs);
    assign wb_hit_rs  = WbRegWrite & (WbRd == rs);
    assign ex_hit_rt  = valid_q & reg_write_q & (rd_q == rt);
    assign mem_hit_rt = MemRegWrite & (MemRd == rt);
    assign wb_hit_rt  = WbRegWrite & (WbRd == rt);

    always_comb begin
        fwd_rs = ReadData1;
        if (rs == 5'd0)      fwd_rs = 32'd0;
        else if (ex_hit_rs)  fwd_rs = ExResult;
        else if (mem_hit_rs) fwd_rs = MemData;
        else if (wb_hit_rs)  fwd_rs = WbData;

        fwd_rt = ReadData2;
        if (rt == 5'd0)      fwd_rt = 32'd0;
        else if (ex_hit_rt)  fwd_rt = ExResult;
        else if (mem_hit_rt) fwd_rt = MemData;
        else if (wb_hit_rt)  fwd_rt = WbData;
    end

    logic [31:0] imm_ext;
    logic        hazard;
    logic        do_bubble;
    logic        do_load;

    assign imm_ext = dec_sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};

    // Uses only registered EX state and the instruction word, never ExResult.
    assign hazard = valid_q & mem_read_q & (rd_q != 5'd0) & ValidIn & dec_legal &
                    ((rs == rd_q) | (dec_reads_rt & (rt == rd_q)));

    assign StallOut  = StallIn | hazard;
    assign do_load   = ~Flush & ~StallIn & ~hazard & ValidIn & dec_legal;
    assign do_bubble = Flush | (~StallIn & ~do_load);

    always_comb begin
        bus_a_d      = bus_a_q;
        bus_b_d      = bus_b_q;
        alu_ctl_d    = alu_ctl_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        branch_d     = branch_q;
        valid_d      = valid_q;
        illegal_d    = ~Flush & ~StallIn & ~hazard & ValidIn & ~dec_legal;
        if (do_bubble) begin
            bus_a_d      = 32'd0;
            bus_b_d      = 32'd0;
            alu_ctl_d    = ALU_ADD;
            store_data_d = 32'd0;
            rd_d         = 5'd0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            branch_d     = 1'b0;
            valid_d      = 1'b0;
        end else if (do_load) begin
            bus_a_d      = fwd_rs;
            bus_b_d      = dec_use_imm ? imm_ext : fwd_rt;
            alu_ctl_d    = dec_alu;
            store_data_d = dec_reads_rt ? fwd_rt : 32'd0;
            rd_d         = dec_rd;
            reg_write_d  = dec_rw & (dec_rd != 5'd0);
            mem_read_d   = dec_mr;
            mem_write_d  = dec_mw;
            branch_d     = dec_br;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus_a_q      <= 32'd0;
            bus_b_q      <= 32'd0;
            alu_ctl_q    <= 2'd0;
            store_data_q <= 32'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            bus_a_q      <= bus_a_d;
            bus_b_q      <= bus_b_d;
            alu_ctl_q    <= alu_ctl_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            valid_q      <= valid_d;
            illegal_q    <= illegal_d;
        end
    end

    assign BusA        = bus_a_q;
    assign BusB        = bus_b_q;
    assign ALUControl  = alu_ctl_q;
    assign StoreData   = store_data_q;
    assign RdOut       = rd_q;
    assign RegWriteOut = reg_write_q;
    assign MemReadOut  = mem_read_q;
    assign MemWriteOut = mem_write_q;
    assign BranchOut   = branch_q;
    assign ValidOut    = valid_q;
    assign IllegalOut  = illegal_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-and-operand stage that sits directly upstream of the 32-bit ALU in the MIPS pipeline. It decodes the IF/ID instruction into the 2-bit ALU control code and side-band control, and selects operands from the register file, the EX/MEM/WB forwarding paths or the immediate. It registers everything into the ID/EX pipeline register that drives ALU BusA, BusB and ALUControl. It also detects load-use hazards and inserts bubbles.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits and register indices at 5 bits.

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Instruction  in  32  instruction word from IF/ID.
- ValidIn  in  1  Instruction is real; 0 means bubble.
- ReadData1, ReadData2  in  32  register-file reads of rs [25:21] and rt [20:16].
- ExResult  in  32  ALU Output for the instruction now in EX.
- MemRegWrite  in  1  MEM-stage instruction writes a register.
- MemRd  in  5  its destination register.
- MemData  in  32  its write-back value, which is load data for loads.
- WbRegWrite  in  1  WB-stage instruction writes a register.
- WbRd  in  5  its destination register.
- WbData  in  32  its write-back value.
- StallIn  in  1  downstream hold; the whole pipe freezes.
- Flush  in  1  squash the instruction entering EX.
- BusA, BusB  out  32  ALU operands (registered).
- ALUControl  out  2  00 add, 01 xor, 10 sub, 11 slt (registered).
- StoreData  out  32  forwarded rt value for sw.
- RdOut  out  5  destination register.
- RegWriteOut, MemReadOut, MemWriteOut, BranchOut  out  1  control, registered.
- ValidOut  out  1  EX slot holds a real instruction.
- StallOut  out  1  combinational; IF/ID must hold.
- IllegalOut  out  1  one-cycle pulse, registered, for an unsupported opcode or funct.

## Operation
Decode, keyed on opcode [31:26]; for opcode 0, on funct [5:0]:
- Funct 0x20/0x21 -> add; 0x22/0x23 -> sub; 0x26 -> xor; 0x2A -> slt. Rd = [15:11]; BusB = rt.
- 0x08/0x09 addi -> add, sign-extended immediate.
- 0x0A slti -> slt, sign-extended immediate.
- 0x0E xori -> xor, zero-extended immediate.
- 0x23 lw -> add, sign-extended immediate, MemRead.
- 0x2B sw -> add, sign-extended immediate, MemWrite, no RegWrite.
- 0x04 beq -> sub, BusB = rt, Branch, no RegWrite.
- I-type Rd = rt [20:16].
- RegWriteOut is forced to 0 when Rd = 0.
- Any other encoding: load as a bubble (ValidOut 0, all control 0) and pulse IllegalOut.

Forwarding, applied per source register (rs; rt when it is read):
- Priority: EX, then MEM, then WB, then register file.
- EX hit: ValidOut & RegWriteOut & RdOut = src & src != 0 -> ExResult.
- MEM hit: MemRegWrite & MemRd = src & src != 0 -> MemData.
- WB hit: same rule -> WbData.
- Register 0 always reads 0, regardless of any source.

Load-use hazard:
- Condition: ValidOut & MemReadOut & RdOut != 0, and the incoming ValidIn instruction reads RdOut as rs, or as rt for R-type, sw or beq.
- Response: StallOut = 1; the next cycle loads a bubble.
- The same instruction is re-presented the following cycle and then forwards from MEM.

Priority per edge: Reset > Flush > StallIn > hazard bubble > normal load.
- Flush loads a bubble even while StallIn is high.
- StallIn holds every output register unchanged; StallOut = 1.
- A bubble clears ValidOut, RegWriteOut, MemReadOut, MemWriteOut and BranchOut; data outputs are don't-care but are driven 0.

## Timing
- Latency is one cycle: the instruction presented at edge N appears on the outputs after edge N.
- Throughput is one instruction per cycle when there is no hazard or stall.
- Reset: all outputs 0, including ValidOut = 0 and IllegalOut = 0, on the first edge with Reset high. A Reset mid-stall or mid-hazard discards the held instruction.
- StallOut is combinational from Instruction, ValidIn, StallIn and the registered EX state. There is no path from ExResult to StallOut.
- ExResult reaches only the register D inputs; a full ALU delay plus forwarding mux must close within one cycle.
- A load-use hazard costs exactly one bubble cycle. Back-to-back dependent loads each cost one.

## Test plan
- Reset, then addi r1,r0,5 followed by add r2,r1,r1 -> cycle 2: BusA=BusB=5 forwarded from ExResult, ALUControl=00, RdOut=2.
- lw r3,4(r0) followed by sub r4,r3,r1 -> StallOut=1 for one cycle and one bubble (ValidOut=0). Then BusA = MemData (0x0000_00A0 driven), ALUControl=10.
- xori r5,r0,0xFFFF -> BusB=0x0000_FFFF. slti r6,r0,-1 -> BusB=0xFFFF_FFFF, ALUControl=11.
- MEM and WB both write r7 (0x11 vs 0x22) and the incoming instruction reads r7 -> BusA=0x11. A target of r0 with nonzero data -> BusA=0.
- StallIn high for 3 cycles with Flush asserted on the 2nd -> outputs held on cycle 1, then ValidOut=0 after the flush edge.
- Opcode 0x3F -> IllegalOut=1 for one cycle, ValidOut=0. Reset asserted during a load-use stall -> all outputs 0 on the next edge.
